// File: rtl/delay_ctrl_pkg.sv
// delay_ctrl_pkg
//   Shared definitions for the programmable-depth delay line controller:
//   controller state encoding, default stage count and the depth
//   legality check used when a configuration is accepted.
package delay_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_FILL  = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  localparam int DEF_MAX_DEPTH = 8;

  // Legal depths are 1..max_depth inclusive.
  function automatic logic depth_legal(input int depth, input int max_depth);
    return (depth >= 1) && (depth <= max_depth);
  endfunction

endpackage

// File: rtl/delay_stage.sv
// delay_stage
//   One single-bit delay stage.
//   Ports:
//     clk   - clock, rising edge
//     rst   - synchronous active-high reset (highest priority)
//     clr_i - synchronous clear
//     en_i  - load d_i when high, otherwise hold
//     d_i   - data in
//     q_o   - registered data out
module delay_stage (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  input  logic d_i,
  output logic q_o
);

  logic q_q;

  always_ff @(posedge clk) begin
    if (rst)        q_q <= 1'b0;
    else if (clr_i) q_q <= 1'b0;
    else if (en_i)  q_q <= d_i;
  end

  assign q_o = q_q;

endmodule

// File: rtl/delay_line_ctrl.sv
// delay_line_ctrl
//   Run-time programmable delay line. A depth is accepted over a
//   valid/ready handshake, the stage bank is flushed for one cycle, then
//   the line fills; out_valid rises once the tap at stage depth-1 holds a
//   real input sample.
//   Ports:
//     clk, rst              - clock, synchronous active-high reset
//     cfg_valid/cfg_depth   - depth configuration offer
//     cfg_ready             - configuration can be accepted (not in FLUSH)
//     cfg_err               - one-cycle pulse after an illegal depth accept
//     en, in_data           - shift enable and input bit
//     out_data, out_valid   - tap at stage depth-1, and its validity
//     busy                  - FLUSH or FILL in progress
module delay_line_ctrl
  import delay_ctrl_pkg::*;
#(
  parameter int MAX_DEPTH = DEF_MAX_DEPTH,
  parameter int DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  input  logic [DEPTH_W-1:0] cfg_depth,
  output logic               cfg_ready,
  output logic               cfg_err,
  input  logic               en,
  input  logic               in_data,
  output logic               out_data,
  output logic               out_valid,
  output logic               busy
);

  state_e               state_q;
  logic [DEPTH_W-1:0]   depth_q;
  logic [DEPTH_W-1:0]   fill_q;
  logic                 err_q;
  logic [MAX_DEPTH-1:0] stage_q;
  logic [MAX_DEPTH-1:0] stage_d;

  logic accept, legal, cfg_load, shift, clr;
  logic tap;

  assign cfg_ready = (state_q != ST_FLUSH);
  assign accept    = cfg_valid && cfg_ready;
  assign legal     = depth_legal(32'(cfg_depth), MAX_DEPTH);
  assign cfg_load  = accept && legal;

  // A legal accept takes priority over a shift on the same edge, so the
  // sample presented with a reconfiguration is dropped.
  assign shift = en && !cfg_load && (state_q == ST_FILL || state_q == ST_RUN);
  assign clr   = (state_q == ST_FLUSH);

  for (genvar k = 0; k < MAX_DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign stage_d[k] = in_data;
    end else begin : g_body
      assign stage_d[k] = stage_q[k-1];
    end

    delay_stage u_stage (
      .clk   (clk),
      .rst   (rst),
      .clr_i (clr),
      .en_i  (shift),
      .d_i   (stage_d[k]),
      .q_o   (stage_q[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      depth_q <= '0;
      fill_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= accept && !legal;
      if (cfg_load) begin
        depth_q <= cfg_depth;
        state_q <= ST_FLUSH;
      end else begin
        case (state_q)
          ST_FLUSH: begin
            fill_q  <= '0;
            state_q <= ST_FILL;
          end
          ST_FILL: begin
            if (en) begin
              fill_q <= fill_q + DEPTH_W'(1);
              // This edge shifts the depth-th sample in, so the tap is live.
              if (fill_q == depth_q - DEPTH_W'(1)) state_q <= ST_RUN;
            end
          end
          default: ;  // IDLE and RUN hold their state
        endcase
      end
    end
  end

  // Tap mux; depth_q is 0 only in IDLE, where no branch matches.
  always_comb begin
    tap = 1'b0;
    for (int k = 0; k < MAX_DEPTH; k++)
      if (depth_q == DEPTH_W'(k + 1)) tap = stage_q[k];
  end

  assign out_data  = (state_q == ST_IDLE) ? 1'b0 : tap;
  assign out_valid = (state_q == ST_RUN);
  assign busy      = (state_q == ST_FLUSH) || (state_q == ST_FILL);
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_delay_line_ctrl.sv
module tb_delay_line_ctrl;

  localparam int MAXD = 8;
  localparam int DW   = $clog2(MAXD + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic [DW-1:0] cfg_depth = '0;
  logic          cfg_ready, cfg_err;
  logic          en = 1'b0;
  logic          in_data = 1'b0;
  logic          out_data, out_valid, busy;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  delay_line_ctrl #(.MAX_DEPTH(MAXD)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_depth(cfg_depth),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .en(en), .in_data(in_data),
    .out_data(out_data), .out_valid(out_valid), .busy(busy)
  );

  // Reference model: history of samples since the last flush (newest first),
  // a count of samples taken, and whether a configuration is live/flushing.
  bit m_cfgd  = 0;
  bit m_flush = 0;
  bit m_err   = 0;
  int m_depth = 0;
  int m_cnt   = 0;
  bit hist[$];

  function automatic bit m_out_data();
    if (!m_cfgd) return 1'b0;
    if (m_depth <= hist.size()) return hist[m_depth-1];
    return 1'b0;
  endfunction

  task automatic model_edge(input bit r, input bit cv, input int cd, input bit e, input bit d);
    bit acc;
    if (r) begin
      m_cfgd = 0; m_flush = 0; m_err = 0; m_depth = 0; m_cnt = 0;
      hist.delete();
      return;
    end
    acc   = cv && !m_flush;
    m_err = acc && !(cd >= 1 && cd <= MAXD);
    if (acc && cd >= 1 && cd <= MAXD) begin
      m_depth = cd; m_cfgd = 1; m_flush = 1;
    end else if (m_flush) begin
      m_flush = 0; m_cnt = 0;
      hist.delete();
    end else if (m_cfgd && e) begin
      hist.push_front(d);
      if (hist.size() > MAXD) void'(hist.pop_back());
      if (m_cnt < MAXD + 1) m_cnt++;
    end
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
  endtask

  task automatic check_model();
    bit run;
    run = m_cfgd && !m_flush && (m_cnt >= m_depth);
    chk("out_data",  out_data,  m_out_data());
    chk("out_valid", out_valid, run);
    chk("cfg_ready", cfg_ready, !m_flush);
    chk("cfg_err",   cfg_err,   m_err);
    chk("busy",      busy,      m_flush || (m_cfgd && !run));
  endtask

  // Drive one edge's inputs, advance the model, sample on the falling edge.
  task automatic step(input bit r, input bit cv, input int cd, input bit e, input bit d);
    rst = r; cfg_valid = cv; cfg_depth = DW'(cd); en = e; in_data = d;
    @(posedge clk);
    model_edge(r, cv, cd & ((1 << DW) - 1), e, d);
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    bit r, cv; int cd; bit e, d;
    bit od, ov, bz, er, rd;
  } vec_t;

  vec_t tbl[$];

  task automatic addv(input bit r, cv, input int cd, input bit e, d, od, ov, bz, er, rd);
    vec_t v;
    v.r = r; v.cv = cv; v.cd = cd; v.e = e; v.d = d;
    v.od = od; v.ov = ov; v.bz = bz; v.er = er; v.rd = rd;
    tbl.push_back(v);
  endtask

  bit b0, b1;

  initial begin
    // Depth 3, inputs 1,0,1,1,0, then illegal depths 0 and 9 while running.
    //     r cv cd e d   od ov bz er rd
    addv(1, 0, 0, 0, 0,  0, 0, 0, 0, 1);
    addv(0, 1, 3, 0, 0,  0, 0, 1, 0, 0);
    addv(0, 0, 0, 0, 0,  0, 0, 1, 0, 1);
    addv(0, 0, 0, 1, 1,  0, 0, 1, 0, 1);
    addv(0, 0, 0, 1, 0,  0, 0, 1, 0, 1);
    addv(0, 0, 0, 1, 1,  1, 1, 0, 0, 1);
    addv(0, 0, 0, 1, 1,  0, 1, 0, 0, 1);
    addv(0, 0, 0, 1, 0,  1, 1, 0, 0, 1);
    addv(0, 0, 0, 1, 0,  1, 1, 0, 0, 1);
    addv(0, 0, 0, 1, 0,  0, 1, 0, 0, 1);
    addv(0, 1, 0, 0, 0,  0, 1, 0, 1, 1);
    addv(0, 0, 0, 0, 0,  0, 1, 0, 0, 1);
    addv(0, 1, 9, 1, 1,  0, 1, 0, 1, 1);
    addv(0, 0, 0, 1, 0,  0, 1, 0, 0, 1);
    addv(0, 0, 0, 1, 0,  1, 1, 0, 0, 1);

    // Reset, then toggling data with en high and no configuration.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 1, i[0]);
      chk("idle_out_valid", out_valid, 1'b0);
      chk("idle_out_data",  out_data,  1'b0);
      chk("idle_cfg_ready", cfg_ready, 1'b1);
    end

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].cv, tbl[i].cd, tbl[i].e, tbl[i].d);
      chk($sformatf("tbl%0d_out_data", i),  out_data,  tbl[i].od);
      chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].ov);
      chk($sformatf("tbl%0d_busy", i),      busy,      tbl[i].bz);
      chk($sformatf("tbl%0d_cfg_err", i),   cfg_err,   tbl[i].er);
      chk($sformatf("tbl%0d_cfg_ready", i), cfg_ready, tbl[i].rd);
    end

    // Depth 5 with gapped enable: valid only after the 5th enabled edge.
    step(0, 1, 5, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1); step(0, 0, 0, 0, 0); step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1); step(0, 0, 0, 0, 1); step(0, 0, 0, 1, 0);
    chk("d5_not_yet_valid", out_valid, 1'b0);
    step(0, 0, 0, 1, 1);
    chk("d5_valid", out_valid, 1'b1);
    chk("d5_first_sample", out_data, 1'b1);

    // Depth 4 running, reconfigure to 2 with en on the accept edge.
    step(0, 1, 4, 0, 0);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1'($urandom));
    chk("d4_running", out_valid, 1'b1);
    step(0, 1, 2, 1, 1);
    chk("reconf_flush_busy", busy, 1'b1);
    chk("reconf_flush_invalid", out_valid, 1'b0);
    step(0, 0, 0, 1, 1);
    chk("reconf_cleared", out_data, 1'b0);
    b0 = 1'($urandom); b1 = 1'($urandom);
    step(0, 0, 0, 1, b0);
    chk("d2_after_1", out_valid, 1'b0);
    step(0, 0, 0, 1, b1);
    chk("d2_after_2_valid", out_valid, 1'b1);
    chk("d2_after_2_data", out_data, b0);

    // Reset during FILL at depth 6 with a simultaneous config offer.
    step(0, 1, 6, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1); step(0, 0, 0, 1, 1);
    step(1, 1, 3, 1, 1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 1'b0);
    chk("rst_ready", cfg_ready, 1'b1);
    step(0, 0, 0, 1, 1);
    chk("rst_cfg_dropped", busy, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 149) == 0, $urandom_range(0, 11) == 0,
           ($urandom_range(0, 19) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8),
           $urandom_range(0, 3) != 0, 1'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/delay_line_ctrl.md
# delay_line_ctrl

Programmable-depth delay line controller: owns a bank of MAX_DEPTH single-bit delay stages and sequences them as a delay line whose length is selected at run time. It accepts a depth configuration through a valid/ready handshake, flushes the stages, and tracks fill. It raises `out_valid` only once the tapped output carries real input history. It sits between an upstream bit source and any consumer that needs a run-time-selectable fixed latency.

## Interface
Parameters:
- `MAX_DEPTH`, 8: number of delay stages; legal depths are 1..MAX_DEPTH.
- `DEPTH_W`, $clog2(MAX_DEPTH+1): width of depth and fill-count fields.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_valid`  in  1  depth configuration offered.
- `cfg_depth`  in  DEPTH_W  requested delay in enabled cycles.
- `cfg_ready`  out  1  controller can accept a configuration.
- `cfg_err`  out  1  one-cycle pulse: accepted configuration had an illegal depth.
- `en`  in  1  shift enable; the line advances only when high.
- `in_data`  in  1  input bit, sampled on enabled edges.
- `out_data`  out  1  tap at stage `depth-1`.
- `out_valid`  out  1  `out_data` holds an input sample, not flush residue.
- `busy`  out  1  state is FLUSH or FILL.

## Operation
- States: IDLE, FLUSH, FILL, RUN.
- Reset values: state IDLE, depth register 0, all stages 0, fill counter 0. Outputs: `out_data` 0, `out_valid` 0, `cfg_ready` 1, `cfg_err` 0, `busy` 0.
- A configuration is accepted on an edge where `cfg_valid && cfg_ready`. `cfg_ready` = state is not FLUSH.
- Accept with legal depth (1..MAX_DEPTH): latch depth, go to FLUSH. This applies from IDLE, FILL or RUN, and abandons any fill in progress.
- Accept with illegal depth (0 or >MAX_DEPTH): state, depth and stages are unchanged. `cfg_err` is high for the following cycle.
- IDLE: `en` is ignored and the stages hold.
- FLUSH: lasts exactly one cycle. It clears all stages and the fill counter synchronously, then goes to FILL. `en` is ignored.
- FILL: on each `en` edge, stage0 <= `in_data`, stage[k] <= stage[k-1], and the fill counter increments. On the `en` edge where fill count == depth-1, go to RUN.
- RUN: shift on `en`; `out_valid` stays 1.
- `out_valid` = (state == RUN). `out_data` = stage[depth-1]; it is 0 in IDLE.
- Simultaneous legal accept and `en` on the same edge: the configuration wins and the sample is dropped, because no shift occurs.
- `en` low in FILL/RUN: full hold, with no counter change.
- Reset mid-operation: returns to the reset values on the next edge regardless of state. Reset overrides a simultaneous accept.

## Timing
- Accept edge T: FLUSH during cycle T+1 (`busy`=1, `cfg_ready`=0), FILL from T+2.
- With `en` held high from T+2: `in_data` sampled at edge T+2+j appears on `out_data` after edge T+2+j+depth-1. It is stable for the cycle before edge T+2+j+depth.
- `out_valid` rises after the depth-th enabled edge in FILL.
- Steady-state latency: exactly `depth` enabled edges from sampling to `out_data`. The output is a register tap through a mux, with no extra register stage.
- `cfg_err` is registered: high for exactly the cycle after the rejecting edge.

## Structure
- Package `delay_ctrl_pkg`: state enum (IDLE, FLUSH, FILL, RUN), default `MAX_DEPTH`, depth legality check function.
- Sub-module `delay_stage`: one-bit flop with synchronous active-high `rst`, synchronous `clr` and `en`. Priority: rst > clr > en > hold. Instantiate MAX_DEPTH times in a generate loop.
- Controller FSM, fill counter and output tap mux live in `delay_line_ctrl`.

## Test plan
- Reset, then `en`=1 with `in_data` toggling, and no config -> `out_valid`=0, `out_data`=0, `cfg_ready`=1 throughout.
- Config depth 3, `en`=1, `in_data` = 1,0,1,1,0 -> `busy` for 1 cycle then through fill; `out_valid` rises after the 3rd enabled edge. `out_data` sequence is 1,0,1,1,0, lagging input by 3 edges.
- Depth 5 with `en` pattern 1,0,1,1,0,1,1 -> `out_valid` rises only after 5 enabled edges; held edges change nothing.
- In RUN at depth 4, reconfigure to depth 2 with `en`=1 on the accept edge -> that sample is dropped, then one FLUSH cycle with all stages cleared. `out_valid` is low until 2 fresh enabled edges.
- Config depth 0, then depth MAX_DEPTH+1, while in RUN -> one `cfg_err` pulse each, and the line keeps delaying at the old depth unchanged.
- Assert `rst` during FILL at depth 6 with a simultaneous `cfg_valid` -> next cycle is in the full reset state and the config is not accepted.
